lsu_dbus: RTL and testbench
===========================

# lsu_dbus

Load/store unit sitting directly upstream of the data memory on the data bus. It accepts one load or store per request from the core's memory stage and checks its alignment. It then issues a single-beat bus transaction with the correct byte selects and lane-replicated write data, waits for `dbus_done`, and returns sign- or zero-extended load data as a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 7: word-address width driven on `dbus_addr` (byte address bits `[ADDR_W+1:2]`).
- `TIMEOUT_CYC`, 15: maximum WAIT cycles before abort (used only with `LSU_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_misalign`  out  1  request rejected: misaligned or illegal size.
- `rsp_err`  out  1  bus timeout abort.
- `dbus_addr`  out  ADDR_W  word address.
- `dbus_wr`  out  1  write strobe qualifier.
- `dbus_cyc_o`  out  1  bus cycle in progress.
- `dbus_stb_o`  out  1  transfer strobe.
- `dbus_sel`  out  4  byte lane selects.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_rdata`  in  32  memory read data, valid while `dbus_done` is high.
- `dbus_done`  in  1  transfer complete, one cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - On `req_valid`, the request is accepted and the address offset `off = req_addr[1:0]` is checked.
  - Illegal requests go to RESP with `rsp_misalign=1`; no bus activity occurs. Illegal means: size 11, half with `off[0]=1`, or word with `off!=0`.
  - Otherwise bus outputs are registered and the FSM goes to ISSUE.
- **Byte-select rules**
  - Byte: `sel = 4'b0001 << off`.
  - Half: `off=0` gives 0011; `off=2` gives 1100.
  - Word: 1111.
- **Write-data rules**
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: unchanged.
- **ISSUE**: `cyc=stb=1` for exactly one cycle, then WAIT. `stb` is never held longer, so the memory performs exactly one access.
- **WAIT**
  - `cyc=1`, `stb=0`, until `dbus_done`.
  - On `dbus_done`, load data is captured, lane-extracted by `off`, and extended.
  - Extension: byte extends from bit 7 and half from bit 15; the extension is signed unless `req_unsigned`. `req_unsigned` is ignored for words.
  - The FSM then goes to RESP.
- **RESP**: `rsp_valid=1` for one cycle, then IDLE. There is no response backpressure.
- `dbus_done` is ignored outside WAIT, including a stray done after reset.
- Bus outputs (`addr/sel/wdata/wr`) are held stable from ISSUE through the end of WAIT.

## Timing
- Reset value: all outputs 0, FSM in IDLE. Note `req_ready` is combinationally 1 in IDLE, so it reads 1 once `rst_n` is high.
- Reset mid-transaction: immediate return to IDLE and `cyc/stb` drop asynchronously. Any in-flight memory access is abandoned and its response is never presented.
- Normal latency: accept at cycle 0, ISSUE (stb) at cycle 1, memory `dbus_done` at cycle 2, `rsp_valid` at cycle 3. Next accept is possible at cycle 4.
- Misaligned latency: accept at cycle 0, `rsp_valid` with `rsp_misalign` at cycle 1.
- `req_*` is sampled only on the accepting edge; later changes have no effect.

## Configuration
- Macro `LSU_TIMEOUT_EN`.
- Defined:
  - A 4-bit+ counter runs in WAIT.
  - After `TIMEOUT_CYC` cycles without `dbus_done`, `cyc` drops and the FSM goes to RESP with `rsp_err=1` and `rsp_rdata=0`.
  - The counter clears on WAIT entry.
- Undefined: WAIT waits indefinitely; `rsp_err` is tied 0; no counter logic is present.

## Structure
- Package `lsu_pkg`:
  - size encodings (`SZ_B`, `SZ_H`, `SZ_W`);
  - FSM state enum;
  - sel constants (`SEL_W=4'b1111`, `SEL_HLO=4'b0011`, `SEL_HHI=4'b1100`).
- Sub-module `lsu_align`: purely combinational. It produces the misalign flag, sel and replicated wdata from size/offset/data, and extracts and extends load data from rdata/size/offset/unsigned. `lsu_dbus` holds the FSM, registers and optional timeout.

## Test plan
- Word store `addr=0x10`, `wdata=0xDEADBEEF`, then word load of same address -> bus `addr=4`, `sel=1111`; `rsp_rdata=0xDEADBEEF`; `rsp_valid` 3 cycles after accept.
- Byte store `0xA5` at `0x13`, then load `0x13` both signed and unsigned -> `sel=1000`, `wdata=0xA5A5A5A5`; rdata `0xFFFFFFA5` signed, `0x000000A5` unsigned.
- Half load at `0x22` holding `0x8001` in `[31:16]` -> `sel=1100`; signed `0xFFFF8001`, unsigned `0x00008001`.
- Word at `0x11`, half at `0x03`, size 11 -> each gives `rsp_misalign=1` at cycle 1, `stb` never asserted.
- `rst_n` pulsed low during WAIT, then a late `dbus_done` -> outputs 0, IDLE, no `rsp_valid`.
- With `LSU_TIMEOUT_EN`, `dbus_done` held 0 -> `rsp_err=1` after `TIMEOUT_CYC` WAIT cycles, `cyc` low; without the macro -> still in WAIT after 100 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte-lane selects.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] SEL_W   = 4'b1111;
  localparam logic [3:0] SEL_HLO = 4'b0011;
  localparam logic [3:0] SEL_HHI = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_dbus_if.sv
// Single-beat data-bus interface between the LSU (master) and data memory (slave).
interface lsu_dbus_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] dbus_addr;
  logic              dbus_wr;
  logic              dbus_cyc_o;
  logic              dbus_stb_o;
  logic [3:0]        dbus_sel;
  logic [31:0]       dbus_wdata;
  logic [31:0]       dbus_rdata;
  logic              dbus_done;

  modport master (
    output dbus_addr, dbus_wr, dbus_cyc_o, dbus_stb_o, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_done
  );

  modport slave (
    input  dbus_addr, dbus_wr, dbus_cyc_o, dbus_stb_o, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_done
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper: store-side lane selects/replication and load-side
// lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext;
  logic signed [31:0] half_ext;

  always_comb begin
    misalign  = 1'b0;
    sel       = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_B: begin
        sel       = 4'b0001 << req_off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        misalign  = req_off[0];
        sel       = req_off[1] ? SEL_HHI : SEL_HLO;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        misalign = (req_off != 2'b00);
        sel      = SEL_W;
      end
      default: misalign = 1'b1;
    endcase
  end

  // Signed lanes widen through signed assignment; the unsigned path zero-fills instead.
  always_comb begin
    byte_s    = rdata[{ld_off, 3'b000} +: 8];
    half_s    = ld_off[1] ? rdata[31:16] : rdata[15:0];
    byte_ext  = byte_s;
    half_ext  = half_s;
    rdata_ext = rdata;
    case (ld_size)
      SZ_B:    rdata_ext = ld_unsigned ? {24'b0, byte_s} : byte_ext;
      SZ_H:    rdata_ext = ld_unsigned ? {16'b0, half_s} : half_ext;
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dbus.sv
// Load/store unit front end: one aligned single-beat data-bus access per request.
// Optional WAIT-state bus timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_dbus
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_err,
  lsu_dbus_if.master        dbus
);

  lsu_state_e  state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        req_mis;
  logic [3:0]  req_sel;
  logic [31:0] req_wrep;
  logic [31:0] ld_ext;
  logic        unused_addr_hi;

  assign req_ready      = (state == ST_IDLE);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  lsu_align u_align (
    .req_size    (req_size),
    .req_off     (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .misalign    (req_mis),
    .sel         (req_sel),
    .wdata_rep   (req_wrep),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (dbus.dbus_rdata),
    .rdata_ext   (ld_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 15) ? $clog2(TIMEOUT_CYC + 1) : 4;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      off_q           <= 2'b00;
      size_q          <= 2'b00;
      uns_q           <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_misalign    <= 1'b0;
      dbus.dbus_addr  <= '0;
      dbus.dbus_wr    <= 1'b0;
      dbus.dbus_cyc_o <= 1'b0;
      dbus.dbus_stb_o <= 1'b0;
      dbus.dbus_sel   <= 4'b0000;
      dbus.dbus_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (req_mis) begin
              state        <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b1;
            end else begin
              state           <= ST_ISSUE;
              dbus.dbus_addr  <= req_addr[ADDR_W+1:2];
              dbus.dbus_wr    <= req_we;
              dbus.dbus_sel   <= req_sel;
              dbus.dbus_wdata <= req_wrep;
              dbus.dbus_cyc_o <= 1'b1;
              dbus.dbus_stb_o <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // Strobe lasts one cycle so the memory sees exactly one access.
          state           <= ST_WAIT;
          dbus.dbus_stb_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
        end
        ST_WAIT: begin
          if (dbus.dbus_done) begin
            state           <= ST_RESP;
            rsp_valid       <= 1'b1;
            rsp_rdata       <= dbus.dbus_wr ? 32'h0 : ld_ext;
            dbus.dbus_cyc_o <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wr    <= 1'b0;
            dbus.dbus_sel   <= 4'b0000;
            dbus.dbus_wdata <= '0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state           <= ST_RESP;
            rsp_valid       <= 1'b1;
            rsp_rdata       <= 32'h0;
            err_q           <= 1'b1;
            dbus.dbus_cyc_o <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wr    <= 1'b0;
            dbus.dbus_sel   <= 4'b0000;
            dbus.dbus_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state        <= ST_IDLE;
          rsp_valid    <= 1'b0;
          rsp_rdata    <= 32'h0;
          rsp_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          err_q        <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dbus.sv
// Bench for lsu_dbus: directed vector table, hand-written reset/timeout sequences and
// randomized traffic checked against a byte-addressed memory model.
module tb_lsu_dbus;

  localparam int ADDR_W      = 7;
  localparam int TIMEOUT_CYC = 15;
  localparam int NWORDS      = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        rsp_err;

  lsu_dbus_if #(.ADDR_W(ADDR_W)) dbus_i ();

  lsu_dbus #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign),
    .rsp_err      (rsp_err),
    .dbus         (dbus_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] slave_mem [0:NWORDS-1];
  logic [7:0]  mbytes    [0:4*NWORDS-1];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [6:0]  baddr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---- reference model: byte-addressed memory and size arithmetic ----
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b11) return 1'b1;
    return (int'(off) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [1:0] off);
    int m;
    m = ((1 << nbytes(size)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int n;
    n = nbytes(size);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int a;
    a = int'(addr[ADDR_W+1:0]);
    for (int i = 0; i < nbytes(size); i++) mbytes[a + i] = wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    int a, n;
    a = int'(addr[ADDR_W+1:0]);
    n = nbytes(size);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[a + i];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  // ---- one request through the DUT with a responsive memory slave ----
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int extra,
                         input logic exp_mis, input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                         input logic [6:0] exp_baddr, input logic [31:0] exp_rd);
    logic [6:0] wa;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    chk("ready_busy", req_ready, 0);
    if (exp_mis) begin
      chk("mis_rsp_valid", rsp_valid, 1);
      chk("mis_flag", rsp_misalign, 1);
      chk("mis_rdata", rsp_rdata, 0);
      chk("mis_stb", dbus_i.dbus_stb_o, 0);
      chk("mis_cyc", dbus_i.dbus_cyc_o, 0);
      @(negedge clk);
      chk("mis_pulse_end", rsp_valid, 0);
      chk("mis_stb_after", dbus_i.dbus_stb_o, 0);
    end else begin
      chk("issue_stb", dbus_i.dbus_stb_o, 1);
      chk("issue_cyc", dbus_i.dbus_cyc_o, 1);
      chk("issue_sel", dbus_i.dbus_sel, exp_sel);
      chk("issue_wdata", dbus_i.dbus_wdata, exp_wd);
      chk("issue_addr", dbus_i.dbus_addr, exp_baddr);
      chk("issue_wr", dbus_i.dbus_wr, we);
      chk("issue_rsp", rsp_valid, 0);
      wa = dbus_i.dbus_addr;
      if (dbus_i.dbus_wr)
        for (int i = 0; i < 4; i++)
          if (dbus_i.dbus_sel[i]) slave_mem[wa][8*i +: 8] = dbus_i.dbus_wdata[8*i +: 8];
      for (int d = 0; d < extra; d++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_cyc", dbus_i.dbus_cyc_o, 1);
        chk("wait_stb", dbus_i.dbus_stb_o, 0);
        chk("wait_sel_held", dbus_i.dbus_sel, exp_sel);
        chk("wait_rsp", rsp_valid, 0);
      end
      @(posedge clk); #1;
      dbus_i.dbus_done  = 1'b1;
      dbus_i.dbus_rdata = slave_mem[dbus_i.dbus_addr];
      @(negedge clk);
      chk("done_cyc", dbus_i.dbus_cyc_o, 1);
      chk("done_stb", dbus_i.dbus_stb_o, 0);
      chk("done_addr_held", dbus_i.dbus_addr, exp_baddr);
      chk("done_rsp", rsp_valid, 0);
      @(posedge clk); #1;
      dbus_i.dbus_done  = 1'b0;
      dbus_i.dbus_rdata = $urandom;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_misalign", rsp_misalign, 0);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_cyc", dbus_i.dbus_cyc_o, 0);
      @(negedge clk);
      chk("rsp_pulse_end", rsp_valid, 0);
    end
  endtask

  initial begin
    logic        we, uns, mis;
    logic [1:0]  sz;
    logic [31:0] ad, wd, rd;

    dbus_i.dbus_done  = 1'b0;
    dbus_i.dbus_rdata = '0;
    for (int w = 0; w < NWORDS; w++) begin
      slave_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) mbytes[4*w + b] = slave_mem[w][8*b +: 8];
    end

    // ---- reset state ----
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_misalign", rsp_misalign, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_cyc", dbus_i.dbus_cyc_o, 0);
    chk("rst_stb", dbus_i.dbus_stb_o, 0);
    chk("rst_sel", dbus_i.dbus_sel, 0);
    chk("rst_addr", dbus_i.dbus_addr, 0);
    chk("rst_wdata", dbus_i.dbus_wdata, 0);
    chk("rst_wr", dbus_i.dbus_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // ---- stray done while idle ----
    dbus_i.dbus_done = 1'b1;
    @(negedge clk);
    dbus_i.dbus_done = 1'b0;
    chk("stray_rsp", rsp_valid, 0);
    chk("stray_cyc", dbus_i.dbus_cyc_o, 0);
    chk("stray_ready", req_ready, 1);

    // ---- directed vector table ----
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF, 7'd4, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b0, 4'hF, 32'h12345678, 7'd4, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'h123456A5, 1'b0, 4'h8, 32'hA5A5A5A5, 7'd4, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 4'h8, 32'h0,        7'd4, 32'hFFFFFFA5});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b0, 4'h8, 32'h0,        7'd4, 32'h000000A5});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        1'b0, 4'hF, 32'h0,        7'd4, 32'hA5ADBEEF});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        1'b0, 4'h1, 32'h0,        7'd4, 32'h000000EF});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b0, 4'hC, 32'h80018001, 7'd8, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        1'b0, 4'hC, 32'h0,        7'd8, 32'hFFFF8001});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        1'b0, 4'hC, 32'h0,        7'd8, 32'h00008001});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        1'b1, 4'h0, 32'h0,        7'd0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        1'b1, 4'h0, 32'h0,        7'd0, 32'h0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h00, 32'h55AA55AA, 1'b1, 4'h0, 32'h0,        7'd0, 32'h0});
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
              vecs[i].mis, vecs[i].sel, vecs[i].wd, vecs[i].baddr, vecs[i].rd);
      if (vecs[i].we && !vecs[i].mis) model_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
    end

    // ---- reset during WAIT, then a late done ----
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_cyc", dbus_i.dbus_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc_drop", dbus_i.dbus_cyc_o, 0);
    chk("async_stb_drop", dbus_i.dbus_stb_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dbus_i.dbus_done  = 1'b1;
    dbus_i.dbus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_done_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    dbus_i.dbus_done = 1'b0;
    @(negedge clk);
    chk("late_done_rsp2", rsp_valid, 0);
    chk("late_done_rdata", rsp_rdata, 0);
    chk("late_done_cyc", dbus_i.dbus_cyc_o, 0);
    chk("late_done_sel", dbus_i.dbus_sel, 0);
    chk("late_done_ready", req_ready, 1);

    // ---- no done from memory ----
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_wait_cyc", dbus_i.dbus_cyc_o, 1);
      chk("to_wait_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_cyc", dbus_i.dbus_cyc_o, 0);
    @(negedge clk);
    chk("to_pulse_end", rsp_valid, 0);
    chk("to_err_clear", rsp_err, 0);
`else
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k % 25 == 24) begin
        chk("hang_cyc", dbus_i.dbus_cyc_o, 1);
        chk("hang_stb", dbus_i.dbus_stb_o, 0);
        chk("hang_rsp", rsp_valid, 0);
        chk("hang_err", rsp_err, 0);
      end
    end
    @(posedge clk); #1;
    dbus_i.dbus_done  = 1'b1;
    dbus_i.dbus_rdata = slave_mem[4];
    @(posedge clk); #1;
    dbus_i.dbus_done = 1'b0;
    @(negedge clk);
    chk("hang_release_rsp", rsp_valid, 1);
    chk("hang_release_rdata", rsp_rdata, model_load(2'd2, 1'b0, 32'h10));
    @(negedge clk);
`endif

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        dbus_i.dbus_done = 1'b1;
        @(negedge clk);
        dbus_i.dbus_done = 1'b0;
        chk("rand_stray_rsp", rsp_valid, 0);
      end
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad  = $urandom;
      wd  = $urandom;
      mis = model_mis(sz, ad[1:0]);
      rd  = (we || mis) ? 32'h0 : model_load(sz, uns, ad);
      run_txn(we, sz, uns, ad, wd, $urandom_range(0, 3), mis,
              mis ? 4'h0 : model_sel(sz, ad[1:0]), mis ? 32'h0 : model_wd(sz, wd),
              ad[ADDR_W+1:2], rd);
      if (we && !mis) model_store(sz, ad, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
